serial_adder_scheduler: RTL and testbench
=========================================

# serial_adder_scheduler

Shares one bit-serial full adder between two requesters. Each requester presents a pair of WIDTH-bit operands with a valid/ready handshake. A round-robin arbiter grants one request at a time. The block then shifts the operands LSB-first through the 1-bit adder and returns the parallel sum, carry-out and requester ID on a result valid/ready port. It sits between parallel producers and the area-minimal serial adder datapath, and it is the only block that sequences and clears that adder.

## Interface

- WIDTH, 8, operand/sum width in bits; legal range 2..32.

- clk  input  1  single clock; all flops on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_a, req1_b  input  WIDTH  requester 1 operands.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_sum  output  WIDTH  (a + b) mod 2^WIDTH.
- res_carry  output  1  carry-out, bit WIDTH of a + b.
- res_id  output  1  requester that owns the result.

## Operation

- The block has three states.
  - IDLE: arbitrate and accept a request.
  - ADD: WIDTH cycles, one bit per cycle.
  - DONE: hold the result until it is taken.
- Priority register prio:
  - Reset value selects requester 0.
  - After each completed result handshake, prio points to the requester not just served.
- Grant, evaluated only in IDLE:
  - If the prio requester is valid, grant it.
  - Otherwise, if the other requester is valid, grant the other.
  - Otherwise, no grant.
- reqN_ready = (state == IDLE) & grantN. It is combinational from the valids and prio.
  - At most one ready is high in any cycle.
  - Both readies are 0 outside IDLE.
- Accept = valid & ready on the edge. On accept:
  - Capture the operands into shift registers opA and opB.
  - Capture the requester index into res_id.
  - Clear bit counter cnt to 0.
  - Synchronously clear the adder carry.
  - Go to ADD.
- ADD, each cycle:
  - Feed opA[0], opB[0] and the carry to the full adder.
  - Shift the sum bit into the MSB of the result shift register.
  - Shift opA and opB right by one.
  - Register carry_d into the carry flop.
  - Increment cnt.
- On the cycle with cnt == WIDTH-1:
  - Store carry_d into res_carry.
  - Go to DONE.
- DONE:
  - res_valid = 1.
  - res_sum, res_carry and res_id are stable while res_ready is low.
  - When res_ready is high at an edge, go to IDLE and update prio.
- The full adder uses only ^, &, | and ~:
  - sum = a ^ b ^ c.
  - carry_d = (a & b) | (a & c) | (b & c).
- Requesters hold their operands stable only until their accept edge. Later changes have no effect.

## Timing

- Reset (rst_n low, asynchronous):
  - state = IDLE, prio = requester 0, cnt = 0, carry = 0.
  - res_valid = 0, res_sum = 0, res_carry = 0, res_id = 0.
  - req0_ready and req1_ready follow the grant rule immediately.
- Latency: res_valid rises exactly WIDTH cycles after the accept edge.
- Throughput:
  - With res_ready tied high, one result every WIDTH+2 cycles.
  - The cycles are 1 IDLE, WIDTH ADD and 1 DONE.
  - No new request is accepted in DONE.
- Simultaneous valids: only the prio requester is accepted. The other waits with ready = 0 and its valid held.
- Backpressure: if res_ready is low, DONE persists indefinitely. Both readies stay 0 and prio is unchanged.
- Reset mid-operation: an in-flight operation is discarded and no result is produced. The next accepted operation starts with carry = 0.
- cnt width is $clog2(WIDTH). cnt does not wrap within an operation.

## Structure

- Package serial_adder_sched_pkg:
  - state_t enum {IDLE, ADD, DONE}.
  - Localparam-style function cnt_w(WIDTH) = $clog2(WIDTH).
- Sub-module serial_full_adder_bit contains:
  - Ports clk, rst_n, clr, en, a, b, sum.
  - The carry flop, with asynchronous reset and synchronous clr.
  - The logic-operation full adder.
- The top level holds the FSM, arbiter, shift registers, counter and result registers.

## Test plan

- Reset: hold rst_n low with req0_valid = 1.
  - Required: res_valid = 0 and res_sum = 0.
  - Required: req0_ready = 1 and req1_ready = 0 once rst_n is released.
- Single add: WIDTH = 8, req0 with a = 0x5A and b = 0x3C.
  - Required 8 cycles after accept: res_valid = 1, res_sum = 0x96, res_carry = 0, res_id = 0.
- Overflow: req1 with a = 0xFF and b = 0x01.
  - Required: res_sum = 0x00, res_carry = 1, res_id = 1.
  - Then req0 with a = 0x01 and b = 0x01. Required: res_sum = 0x02, res_carry = 0, which shows the carry was cleared.
- Arbitration: both valid continuously after reset with res_ready = 1.
  - Required: res_id sequence 0, 1, 0, 1.
  - Required: results spaced exactly 10 cycles apart.
- Backpressure: res_ready low for 5 cycles in DONE.
  - Required: outputs stable, both readies 0.
  - Required: the result is consumed on the edge where res_ready rises.
- Mid-op reset: assert rst_n low at ADD cycle 3 of 0xF0 + 0xF0.
  - Required: res_valid stays 0.
  - Then 0x0F + 0x01. Required: res_sum = 0x10, res_carry = 0.

Source files
------------

// File: rtl/serial_adder_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// serial_adder_sched_pkg : shared types and helpers for the scheduler
// Rev 1.0
// ----------------------------------------------------------------------
package serial_adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_full_adder_bit.sv
`default_nettype none
// ----------------------------------------------------------------------
// serial_full_adder_bit : 1-bit full adder with a clearable carry flop
// Rev 1.0
// ----------------------------------------------------------------------
module serial_full_adder_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  logic carry_q;
  logic carry_d;

  always_comb begin
    sum     = a ^ b ^ carry_q;
    carry_d = (a & b) | (a & carry_q) | (b & carry_q);
    cout    = carry_d;
  end

  // clr wins over en so a fresh operation never inherits a stale carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      carry_q <= 1'b0;
    else if (clr)
      carry_q <= 1'b0;
    else if (en)
      carry_q <= carry_d;
  end

endmodule
`default_nettype wire

// File: rtl/serial_adder_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------
// serial_adder_scheduler : round-robin access to one bit-serial adder
// Rev 1.0
// ----------------------------------------------------------------------
module serial_adder_scheduler
  import serial_adder_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id
);

  localparam int            CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             res_valid_q, res_valid_d;
  logic             res_carry_q, res_carry_d;
  logic             res_id_q, res_id_d;

  logic grant0, grant1, accept, fa_sum, fa_cout, add_en;

  always_comb begin
    grant0 = prio_q ? (req0_valid & ~req1_valid) : req0_valid;
    grant1 = prio_q ? req1_valid : (req1_valid & ~req0_valid);
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign add_en     = (state_q == ADD);

  serial_full_adder_bit u_fa (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (add_en),
    .a     (op_a_q[0]),
    .b     (op_b_q[0]),
    .sum   (fa_sum),
    .cout  (fa_cout)
  );

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sum_d       = sum_q;
    res_valid_d = res_valid_q;
    res_carry_d = res_carry_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = req1_ready ? req1_a : req0_a;
          op_b_d   = req1_ready ? req1_b : req0_b;
          res_id_d = req1_ready;
          cnt_d    = '0;
          state_d  = ADD;
        end
      end
      ADD: begin
        sum_d  = {fa_sum, sum_q[WIDTH-1:1]};
        op_a_d = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d = {1'b0, op_b_q[WIDTH-1:1]};
        // hold cnt on the last bit so it never wraps inside an operation
        if (cnt_q == CNT_LAST) begin
          res_carry_d = fa_cout;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          prio_d      = ~res_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      res_valid_q <= 1'b0;
      res_carry_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      res_valid_q <= res_valid_d;
      res_carry_q <= res_carry_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = sum_q;
  assign res_carry = res_carry_q;
  assign res_id    = res_id_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_serial_adder_scheduler : directed plus randomized checks against a model
// Rev 1.0
// ----------------------------------------------------------------------
module tb_serial_adder_scheduler;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry, res_id;

  int checks = 0;
  int errors = 0;
  bit exp_prio = 1'b0;

  always #5 clk = ~clk;

  serial_adder_scheduler #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Full request/result transaction; expected values come from plain arithmetic
  task automatic run_op(input bit v0, input bit v1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input int hold);
    bit        win;
    logic [W:0] expv;
    int        n;
    win  = (v0 && v1) ? exp_prio : v1;
    expv = win ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    n = 0;
    while (!(win ? req1_ready : req0_ready) && n < 30) begin
      @(posedge clk); #2; n++;
    end
    check("grant", {30'd0, req1_ready, req0_ready}, win ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = W'($urandom); req0_b = W'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom);
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, W);
    check("sum", res_sum, expv[W-1:0]);
    check("carry", res_carry, expv[W]);
    check("id", res_id, win);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("bp_ready", {30'd0, req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
      check("bp_valid", res_valid, 1);
      check("bp_sum", res_sum, expv[W-1:0]);
      check("bp_carry", res_carry, expv[W]);
      check("bp_id", res_id, win);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("consumed", res_valid, 0);
    exp_prio = ~win;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_prio = 1'b0;
  endtask

  int   rids[$];
  int   rcyc[$];
  int   cyc;
  int   pat;

  initial begin
    rst_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", res_valid, 0);
    check("rst_sum", res_sum, 0);
    check("rst_carry", res_carry, 0);
    check("rst_id", res_id, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 1);
    check("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0;
    @(posedge clk); #1;

    // Directed: single add, overflow, carry-clear, backpressure
    run_op(1, 0, 8'h5A, 8'h3C, 8'h00, 8'h00, 0);
    run_op(0, 1, 8'h00, 8'h00, 8'hFF, 8'h01, 0);
    run_op(1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0);
    run_op(1, 0, 8'hC3, 8'h7E, 8'h00, 8'h00, 5);

    // Arbitration with both requesters valid continuously
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h90;
    res_ready = 1'b1;
    cyc = 0;
    while (rids.size() < 4 && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (res_valid) begin
        rids.push_back(int'(res_id));
        rcyc.push_back(cyc);
        check("arb_sum", res_sum, res_id ? 32'h10 : 32'h33);
        check("arb_carry", res_carry, res_id ? 32'd1 : 32'd0);
      end
    end
    check("arb_count", rids.size(), 4);
    for (int i = 0; i < rids.size(); i++) begin
      check("arb_id", rids[i], i % 2);
      if (i > 0) check("arb_spacing", rcyc[i] - rcyc[i-1], W + 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;

    // Mid-operation reset discards the operation
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'hF0;
    #1;
    check("mid_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_sum", res_sum, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_prio = 1'b0;
    pat = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (res_valid) pat++;
    end
    check("mid_no_result", pat, 0);
    run_op(1, 0, 8'h0F, 8'h01, 8'h00, 8'h00, 0);

    // Randomized traffic against the arithmetic/round-robin model
    for (int k = 0; k < 30; k++) begin
      pat = $urandom_range(1, 3);
      run_op(pat[0], pat[1], W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
